// File: rtl/four_to_one_mux.sv
// Registered 4:1 multiplexer with capture enable and a valid flag.
// The selected input is captured on an enabled edge, so y has one clock of latency.
module four_to_one_mux #(
    parameter int unsigned             WIDTH     = 1,
    parameter logic [WIDTH-1:0]        RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] y_next;
    logic             y_valid_reg;

    // Per-bit decode keeps each output bit a flat 4-input function of its own column.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_comb begin
                y_next[gi] = a[gi];
                unique case (s)
                    2'b00:   y_next[gi] = a[gi];
                    2'b01:   y_next[gi] = b[gi];
                    2'b10:   y_next[gi] = c[gi];
                    2'b11:   y_next[gi] = d[gi];
                    default: y_next[gi] = a[gi];
                endcase
            end
        end
    endgenerate

    // Reset wins over enable, so a capture requested on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg       <= RESET_VAL;
            y_valid_reg <= 1'b0;
        end else if (en) begin
            y_reg       <= y_next;
            y_valid_reg <= 1'b1;
        end
    end

    assign y       = y_reg;
    assign y_valid = y_valid_reg;

endmodule

// File: tb/tb_four_to_one_mux.sv
// Bench for four_to_one_mux: directed steps followed by random traffic,
// checked against an index-into-array reference model.
module tb_four_to_one_mux;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] a, b, c, d;
    logic [1:0]   s;
    logic [W-1:0] y;
    logic         y_valid;

    int pass_count = 0;
    int total      = 0;

    logic [W-1:0] exp_y;
    logic         exp_v;

    four_to_one_mux #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk(clk), .rst(rst), .en(en),
        .a(a), .b(b), .c(c), .d(d), .s(s),
        .y(y), .y_valid(y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) pass_count++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Drive one set of inputs, optionally check y has not moved before the edge,
    // clock once, advance the model, then check both outputs.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] vc, input logic [W-1:0] vd,
                        input logic [1:0] vs, input bit pre);
        logic [W-1:0] src [4];
        rst = r; en = e; a = va; b = vb; c = vc; d = vd; s = vs;
        #2;
        if (pre) check({tag, "_pre"}, y, exp_y);
        @(posedge clk);
        src[0] = va; src[1] = vb; src[2] = vc; src[3] = vd;
        if (r) begin
            exp_y = '0;
            exp_v = 1'b0;
        end else if (e) begin
            exp_y = src[vs];
            exp_v = 1'b1;
        end
        #1;
        check(tag, y, exp_y);
        check({tag, "_v"}, {{(W-1){1'b0}}, y_valid}, {{(W-1){1'b0}}, exp_v});
        $display("step %-10s rst=%0b en=%0b s=%0d a=%h b=%h c=%h d=%h -> y=%h v=%0b",
                 tag, r, e, vs, va, vb, vc, vd, y, y_valid);
    endtask

    initial begin
        logic [W-1:0] ones;
        ones  = '1;
        exp_y = '0;
        exp_v = 1'b0;
        rst = 1'b1; en = 1'b1; a = ones; b = ones; c = ones; d = ones; s = 2'b11;

        step("reset0", 1, 1, ones, ones, ones, ones, 2'd3, 0);
        step("reset1", 1, 1, ones, ones, ones, ones, 2'd3, 0);
        step("zero",   0, 1, 0, 0, 0, 0, 2'd0, 0);

        step("iso_a", 0, 1, 1, 0, 0, 0, 2'd1, 0);
        step("iso_b", 0, 1, 0, 1, 0, 0, 2'd2, 0);
        step("iso_c", 0, 1, 0, 0, 1, 0, 2'd3, 0);
        step("iso_d", 0, 1, 0, 0, 0, 1, 2'd0, 0);

        step("sel_a", 0, 1, 1, 0, 0, 0, 2'd0, 1);
        step("sel_b", 0, 1, 0, 1, 0, 0, 2'd1, 1);
        step("sel_c", 0, 1, 0, 0, 1, 0, 2'd2, 1);
        step("sel_d", 0, 1, 0, 0, 0, 1, 2'd3, 1);

        step("hold_cap", 0, 1, 1, 0, 0, 0, 2'd0, 0);
        for (int i = 0; i < 3; i++)
            step("hold", 0, 0, 1, 0, 0, 0, 2'd1, 0);

        step("prio", 1, 1, 1, 0, 0, 0, 2'd0, 0);

        for (int i = 0; i < 300; i++) begin
            step("rand",
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", pass_count, total);
        $finish;
    end

endmodule
